countdown_timer: RTL and testbench

Loadable down-counter with a start/done handshake. It is the decrementing counterpart of the team's loadable 4-bit up-counter. Software or a controlling FSM loads a count, pulses `start`, and gets a single-cycle `done` pulse when the count reaches zero, with optional automatic reload. It sits beside the up-counter in the timing/sequencing datapath and drives timeouts and delay intervals.

---
 rtl/timer_pkg.sv | 12 +
 rtl/countdown_timer_tick_gen.sv | 32 +++
 rtl/countdown_timer.sv | 113 +++++++++++
 tb/tb_countdown_timer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timing/sequencing counters.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: emits one enable tick every PRESCALE enabled cycles.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_prescale_cnt;
    logic          w_at_last;

    assign w_at_last = (r_prescale_cnt == LAST);
    assign tick      = en && w_at_last;

    // Count enabled cycles, wrapping on the last one; clr restarts the interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale_cnt <= '0;
        end else if (clr) begin
            r_prescale_cnt <= '0;
        end else if (en) begin
            r_prescale_cnt <= w_at_last ? '0 : r_prescale_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/done handshake and optional auto-reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = TIMER_WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             w_tick;
    logic             w_tick_en;
    logic             w_tick_clr;

    // Prescaler only runs in RUN; held at zero otherwise so every run starts a fresh interval.
    assign w_tick_en  = (r_state == ST_RUN) && !pause;
    assign w_tick_clr = load || (r_state != ST_RUN);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (w_tick_en),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    // Next-state and datapath decode; load overrides everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        if (load) begin
            w_count_nxt  = data;
            w_reload_nxt = data;
            w_state_nxt  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = (r_count != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (w_tick && (r_count != '0)) begin
                        w_count_nxt = r_count - WIDTH'(1);
                        if (r_count == WIDTH'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (auto_reload && (r_reload != '0)) begin
                        w_count_nxt = r_reload;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
            r_zero   <= (w_count_nxt == '0);
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign zero  = r_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: PRESCALE=1 and PRESCALE=3 instances share stimulus.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] data;
    logic       start;
    logic       pause;
    logic       auto_reload;

    logic [3:0] cnt1, cnt3;
    logic       busy1, busy3, done1, done3, zero1, zero3;

    logic [3:0] o_cnt  [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_zero [2];

    assign o_cnt[0]  = cnt1;
    assign o_cnt[1]  = cnt3;
    assign o_busy[0] = busy1;
    assign o_busy[1] = busy3;
    assign o_done[0] = done1;
    assign o_done[1] = done3;
    assign o_zero[0] = zero1;
    assign o_zero[1] = zero3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
        .clk(clk), .reset(reset), .load(load), .data(data), .start(start),
        .pause(pause), .auto_reload(auto_reload),
        .count(cnt1), .busy(busy1), .done(done1), .zero(zero1)
    );

    countdown_timer #(.WIDTH(4), .PRESCALE(3)) u3 (
        .clk(clk), .reset(reset), .load(load), .data(data), .start(start),
        .pause(pause), .auto_reload(auto_reload),
        .count(cnt3), .busy(busy3), .done(done3), .zero(zero3)
    );

    // Reference model: mode 0=idle 1=counting 2=done-cycle; count derived from
    // elapsed unpaused cycles divided by the prescale factor.
    localparam int PS [2] = '{1, 3};
    int m_mode   [2];
    int m_count  [2];
    int m_reload [2];
    int m_d      [2];
    int m_act    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_count[k] = 0; m_reload[k] = 0; m_d[k] = 0; m_act[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                m_count[k] = int'(data); m_reload[k] = int'(data); m_mode[k] = 0;
            end else begin
                case (m_mode[k])
                    0: if (start) begin
                        if (m_count[k] == 0) m_mode[k] = 2;
                        else begin m_mode[k] = 1; m_d[k] = m_count[k]; m_act[k] = 0; end
                    end
                    1: if (!pause) begin
                        m_act[k]++;
                        m_count[k] = m_d[k] - m_act[k] / PS[k];
                        if (m_count[k] == 0) m_mode[k] = 2;
                    end
                    default: begin
                        if (auto_reload && m_reload[k] != 0) begin
                            m_mode[k] = 1; m_d[k] = m_reload[k]; m_act[k] = 0; m_count[k] = m_reload[k];
                        end else begin
                            m_mode[k] = 0; m_count[k] = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 0; data = 0; start = 0; pause = 0; auto_reload = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_cnt[k] !== 4'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 || o_zero[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset k=%0d: count=%0d busy=%b done=%b zero=%b, expected 0 0 0 1",
                         k, o_cnt[k], o_busy[k], o_done[k], o_zero[k]);
            end
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        load = 1; data = 4'd5; step(); load = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (cnt1 !== 4'((i < 5) ? 5 - i : 0) || done1 !== (i == 5) || busy1 !== (i < 5)) begin
                n_fail++;
                $display("FAIL basic cyc=%0d: count=%0d done=%b busy=%b, expected %0d %b %b",
                         i, cnt1, done1, busy1, (i < 5) ? 5 - i : 0, (i == 5), (i < 5));
            end
            n_checks++;
            if (cnt3 !== 4'(m_count[1]) || busy3 !== (m_mode[1] == 1) || done3 !== (m_mode[1] == 2) || zero3 !== (m_count[1] == 0)) begin
                n_fail++;
                $display("FAIL basic_p3 cyc=%0d: count=%0d busy=%b done=%b zero=%b, expected %0d", i, cnt3, busy3, done3, zero3, m_count[1]);
            end
            if (busy1) busy_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != 5) begin
            n_fail++;
            $display("FAIL basic_busy_len: got %0d cycles, expected 5", busy_cycles);
        end
    endtask

    task automatic test_prescale();
        load = 1; data = 4'd2; step(); load = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cnt3 !== 4'((i < 6) ? 2 - i / 3 : 0) || done3 !== (i == 6) || busy3 !== (i < 6)) begin
                n_fail++;
                $display("FAIL prescale cyc=%0d: count=%0d done=%b busy=%b, expected %0d %b %b",
                         i, cnt3, done3, busy3, (i < 6) ? 2 - i / 3 : 0, (i == 6), (i < 6));
            end
            n_checks++;
            if (cnt1 !== 4'(m_count[0]) || busy1 !== (m_mode[0] == 1) || done1 !== (m_mode[0] == 2)) begin
                n_fail++;
                $display("FAIL prescale_p1 cyc=%0d: count=%0d busy=%b done=%b, expected %0d", i, cnt1, busy1, done1, m_count[0]);
            end
            step();
        end
    endtask

    task automatic test_pause();
        int first_done [2] = '{-1, -1};
        load = 1; data = 4'd4; step(); load = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cnt[k] !== 4'(m_count[k]) || o_busy[k] !== (m_mode[k] == 1) || o_done[k] !== (m_mode[k] == 2)) begin
                    n_fail++;
                    $display("FAIL pause k=%0d cyc=%0d: count=%0d busy=%b done=%b, expected %0d", k, i, o_cnt[k], o_busy[k], o_done[k], m_count[k]);
                end
                if (o_done[k] === 1'b1 && first_done[k] < 0) first_done[k] = i;
            end
            pause = (i >= 1 && i <= 3);
            step();
        end
        pause = 0;
        n_checks++;
        if (first_done[0] != 7 || first_done[1] != 15) begin
            n_fail++;
            $display("FAIL pause_done_time: got %0d/%0d, expected 7/15", first_done[0], first_done[1]);
        end
    endtask

    task automatic test_auto_reload();
        auto_reload = 1;
        load = 1; data = 4'd3; step(); load = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (cnt1 !== 4'((i % 4 == 3) ? 0 : 3 - i % 4) || done1 !== (i % 4 == 3) || busy1 !== (i % 4 != 3)) begin
                n_fail++;
                $display("FAIL autoreload cyc=%0d: count=%0d done=%b busy=%b", i, cnt1, done1, busy1);
            end
            n_checks++;
            if (cnt3 !== 4'(m_count[1]) || busy3 !== (m_mode[1] == 1) || done3 !== (m_mode[1] == 2)) begin
                n_fail++;
                $display("FAIL autoreload_p3 cyc=%0d: count=%0d busy=%b done=%b, expected %0d", i, cnt3, busy3, done3, m_count[1]);
            end
            step();
        end
        auto_reload = 0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cnt[k] !== 4'(m_count[k]) || o_busy[k] !== (m_mode[k] == 1) || o_done[k] !== (m_mode[k] == 2)) begin
                    n_fail++;
                    $display("FAIL autoreload_off k=%0d cyc=%0d: count=%0d busy=%b done=%b, expected %0d", k, i, o_cnt[k], o_busy[k], o_done[k], m_count[k]);
                end
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_cnt[k] !== 4'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL autoreload_idle k=%0d: count=%0d busy=%b done=%b, expected 0 0 0", k, o_cnt[k], o_busy[k], o_done[k]);
            end
        end
    endtask

    task automatic test_zero_load();
        load = 1; data = 4'd0; step(); load = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cnt[k] !== 4'd0 || o_busy[k] !== 1'b0 || o_done[k] !== (i == 0) || o_zero[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL zero_load k=%0d cyc=%0d: count=%0d busy=%b done=%b, expected done=%b", k, i, o_cnt[k], o_busy[k], o_done[k], (i == 0));
                end
            end
            step();
        end
    endtask

    task automatic test_load_abort();
        load = 1; data = 4'd5; step(); load = 0;
        start = 1; step(); start = 0;
        step(); step();
        load = 1; data = 4'd9; step(); load = 0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cnt[k] !== 4'd9 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 || o_zero[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_abort k=%0d cyc=%0d: count=%0d busy=%b done=%b, expected 9 0 0", k, i, o_cnt[k], o_busy[k], o_done[k]);
                end
            end
            step();
        end
    endtask

    task automatic test_load_start_same();
        load = 1; start = 1; data = 4'd6; step(); load = 0; start = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_cnt[k] !== 4'd6 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_start k=%0d cyc=%0d: count=%0d busy=%b done=%b, expected 6 0 0", k, i, o_cnt[k], o_busy[k], o_done[k]);
                end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        load = 1; data = 4'd5; step(); load = 0;
        start = 1; step(); start = 0;
        step(); step(); step();
        n_checks++;
        if (cnt1 !== 4'd2 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: count=%0d busy=%b, expected 2 1", cnt1, busy1);
        end
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_cnt[k] !== 4'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 || o_zero[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL areset k=%0d: count=%0d busy=%b done=%b zero=%b, expected 0 0 0 1", k, o_cnt[k], o_busy[k], o_done[k], o_zero[k]);
            end
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_cnt[k] !== 4'd0 || o_busy[k] !== 1'b0 || o_done[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_post k=%0d: count=%0d busy=%b done=%b, expected idle", k, o_cnt[k], o_busy[k], o_done[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            data = 4'($urandom_range(0, 15));
            auto_reload = ($urandom_range(0, 2) == 0);
            load = 1; step(); load = 0;
            start = 1; step(); start = 0;
            for (int c = 0; c < int'($urandom_range(5, 45)); c++) begin
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (o_cnt[k] !== 4'(m_count[k]) || o_busy[k] !== (m_mode[k] == 1) ||
                        o_done[k] !== (m_mode[k] == 2) || o_zero[k] !== (m_count[k] == 0)) begin
                        n_fail++;
                        $display("FAIL random k=%0d it=%0d cyc=%0d: count=%0d busy=%b done=%b zero=%b, expected %0d mode %0d",
                                 k, it, c, o_cnt[k], o_busy[k], o_done[k], o_zero[k], m_count[k], m_mode[k]);
                    end
                end
                pause = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 7) == 0);
                load  = ($urandom_range(0, 24) == 0);
                data  = 4'($urandom_range(0, 15));
                step();
            end
            pause = 0; start = 0; load = 0;
        end
        auto_reload = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_pause();
        test_auto_reload();
        test_zero_load();
        test_load_abort();
        test_load_start_same();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
